// File: rtl/clk_div_sched.sv
// clk_div_sched: runtime-programmable integer clock divider.
// Produces a registered divided clock (high ceil(N/2), low floor(N/2) cycles) and a
// one-cycle tick in the first high cycle of every period. Ratio changes and stop
// requests are accepted over a valid/ready handshake but only take effect at a
// period boundary, so a pulse is never truncated.
//
// Ports:
//   clk_in      - system clock
//   rst         - asynchronous active-high reset
//   cfg_valid   - config request valid
//   cfg_ready   - request can be accepted (low while a change is pending)
//   cfg_en      - 1: run at cfg_div, 0: stop
//   cfg_div     - requested ratio N (must be >= 2 for a run request)
//   div_clk_out - divided clock, registered
//   div_tick    - one-cycle pulse at the start of each divided period
//   busy        - block is running or has a change pending
//   cfg_err     - one-cycle pulse after an accepted run request with cfg_div < 2
module clk_div_sched #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned DEF_DIV = 4
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic             cfg_en,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             div_clk_out,
    output logic             div_tick,
    output logic             busy,
    output logic             cfg_err
);

    typedef enum logic [1:0] {StIdle, StRun, StPend} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cur_div_q, cur_div_d;
    logic [CNT_W-1:0] pend_div_q, pend_div_d;
    logic             pend_en_q, pend_en_d;
    logic             div_clk_q, div_clk_d;
    logic             tick_q, tick_d;
    logic             err_q, err_d;

    logic             xfer;
    logic             div_ok;
    logic             wrap;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W:0]   half;

    assign cfg_ready = (state_q != StPend);
    assign busy      = (state_q != StIdle);
    assign xfer      = cfg_valid && cfg_ready;
    assign div_ok    = (cfg_div >= CNT_W'(2));
    assign wrap      = (cnt_q == (cur_div_q - CNT_W'(1)));
    assign cnt_inc   = wrap ? '0 : (cnt_q + CNT_W'(1));

    // Extra bit so (N+1) does not overflow at the maximum ratio.
    assign half      = ({1'b0, cur_div_d} + (CNT_W + 1)'(1)) >> 1;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cur_div_d  = cur_div_q;
        pend_en_d  = pend_en_q;
        pend_div_d = pend_div_q;
        // Rejected run requests still complete the handshake but change nothing else.
        err_d      = xfer && cfg_en && !div_ok;

        unique case (state_q)
            StIdle: begin
                if (xfer && cfg_en && div_ok) begin
                    cur_div_d = cfg_div;
                    cnt_d     = '0;
                    state_d   = StRun;
                end
            end
            StRun: begin
                cnt_d = cnt_inc;
                if (xfer && (!cfg_en || div_ok)) begin
                    pend_en_d  = cfg_en;
                    pend_div_d = cfg_div;
                    state_d    = StPend;
                end
            end
            StPend: begin
                // Finish the current period at the old ratio; cnt_inc is 0 on wrap.
                cnt_d = cnt_inc;
                if (wrap) begin
                    if (pend_en_q) begin
                        cur_div_d = pend_div_q;
                        state_d   = StRun;
                    end else begin
                        state_d   = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        // Outputs are registered copies of what the next cycle's counter implies.
        div_clk_d = (state_d != StIdle) && ({1'b0, cnt_d} < half);
        tick_d    = (state_d != StIdle) && (cnt_d == '0);
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            cur_div_q  <= CNT_W'(DEF_DIV);
            pend_en_q  <= 1'b0;
            pend_div_q <= '0;
            div_clk_q  <= 1'b0;
            tick_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_div_q  <= cur_div_d;
            pend_en_q  <= pend_en_d;
            pend_div_q <= pend_div_d;
            div_clk_q  <= div_clk_d;
            tick_q     <= tick_d;
            err_q      <= err_d;
        end
    end

    assign div_clk_out = div_clk_q;
    assign div_tick    = tick_q;
    assign cfg_err     = err_q;

endmodule

// File: tb/tb_clk_div_sched.sv
// Directed bench for clk_div_sched: hand-computed waveforms for several ratios,
// deferred ratio change, stop, invalid ratio, boundary ratios and async reset.
module tb_clk_div_sched;

    logic       clk_in = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_valid = 1'b0;
    logic       cfg_en = 1'b0;
    logic [7:0] cfg_div = 8'd0;
    logic       cfg_ready;
    logic       div_clk_out;
    logic       div_tick;
    logic       busy;
    logic       cfg_err;

    int checks = 0;
    int failures = 0;

    clk_div_sched #(
        .CNT_W   (8),
        .DEF_DIV (4)
    ) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_en      (cfg_en),
        .cfg_div     (cfg_div),
        .div_clk_out (div_clk_out),
        .div_tick    (div_tick),
        .busy        (busy),
        .cfg_err     (cfg_err)
    );

    always #5 clk_in = ~clk_in;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // Check one cycle's outputs, then advance past the next clock edge.
    task automatic cyc(input string tag, input logic ec, input logic et, input logic er,
                       input logic eb, input logic ee);
        check_eq({tag, ".clk"},   32'(div_clk_out), 32'(ec));
        check_eq({tag, ".tick"},  32'(div_tick),    32'(et));
        check_eq({tag, ".ready"}, 32'(cfg_ready),   32'(er));
        check_eq({tag, ".busy"},  32'(busy),        32'(eb));
        check_eq({tag, ".err"},   32'(cfg_err),     32'(ee));
        step();
    endtask

    task automatic set_req(input logic en, input logic [7:0] div);
        cfg_valid = 1'b1;
        cfg_en    = en;
        cfg_div   = div;
    endtask

    task automatic clr_req();
        cfg_valid = 1'b0;
        cfg_en    = 1'b0;
        cfg_div   = 8'd0;
    endtask

    initial begin
        logic [7:0] vc;
        logic [7:0] vt;
        logic [7:0] vr;
        int         c;

        // Reset state
        #1;
        check_eq("rst.clk",  32'(div_clk_out), 0);
        check_eq("rst.tick", 32'(div_tick),    0);
        check_eq("rst.err",  32'(cfg_err),     0);
        check_eq("rst.busy", 32'(busy),        0);
        step();
        step();
        rst = 1'b0;
        check_eq("rst.ready", 32'(cfg_ready), 1);
        check_eq("rst.cur_div", 32'(dut.cur_div_q), 4);

        // 1: N=4 -> 1100 repeating
        set_req(1'b1, 8'd4);
        cyc("t1.idle", 0, 0, 1, 0, 0);
        clr_req();
        vc = 8'b1100_1100;
        vt = 8'b1000_1000;
        for (int i = 0; i < 8; i++) cyc("t1.n4", vc[7-i], vt[7-i], 1, 1, 0);

        // 2: request N=3 at cnt=1, old period completes first
        cyc("t2.c0", 1, 1, 1, 1, 0);
        set_req(1'b1, 8'd3);
        cyc("t2.c1", 1, 0, 1, 1, 0);
        clr_req();
        vc = 8'b0011_0110;
        vt = 8'b0010_0100;
        vr = 8'b0011_1111;
        for (int i = 0; i < 8; i++) cyc("t2.n3", vc[7-i], vt[7-i], vr[7-i], 1, 0);

        // 3: switch to N=5, then stop at cnt=0
        set_req(1'b1, 8'd5);
        cyc("t3.c0", 1, 1, 1, 1, 0);
        clr_req();
        cyc("t3.c1", 1, 0, 0, 1, 0);
        cyc("t3.c2", 0, 0, 0, 1, 0);
        set_req(1'b0, 8'd0);
        cyc("t3.n5c0", 1, 1, 1, 1, 0);
        clr_req();
        vc = 8'b1100_0000;
        for (int i = 0; i < 4; i++) cyc("t3.tail", vc[7-i], 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) cyc("t3.idle", 0, 0, 1, 0, 0);

        // 4: invalid ratio while running N=4
        set_req(1'b1, 8'd4);
        cyc("t4.idle", 0, 0, 1, 0, 0);
        clr_req();
        cyc("t4.c0", 1, 1, 1, 1, 0);
        set_req(1'b1, 8'd1);
        cyc("t4.c1", 1, 0, 1, 1, 0);
        clr_req();
        cyc("t4.c2", 0, 0, 1, 1, 1);
        cyc("t4.c3", 0, 0, 1, 1, 0);
        cyc("t4.c0b", 1, 1, 1, 1, 0);
        cyc("t4.c1b", 1, 0, 1, 1, 0);

        // 5: N=2, then N=255
        set_req(1'b1, 8'd2);
        cyc("t5.c2", 0, 0, 1, 1, 0);
        clr_req();
        cyc("t5.c3", 0, 0, 0, 1, 0);
        vc = 8'b1010_0000;
        for (int i = 0; i < 4; i++) cyc("t5.n2", vc[7-i], vc[7-i], 1, 1, 0);
        set_req(1'b1, 8'd255);
        cyc("t5.n2c0", 1, 1, 1, 1, 0);
        clr_req();
        cyc("t5.n2c1", 0, 0, 0, 1, 0);
        for (int i = 0; i < 510; i++) begin
            c = i % 255;
            cyc("t5.n255", (c < 128), (c == 0), 1, 1, 0);
        end

        // 6: async reset mid high phase of N=6
        rst = 1'b1;
        #4;
        rst = 1'b0;
        step();
        check_eq("t6.pre.busy", 32'(busy), 0);
        set_req(1'b1, 8'd6);
        cyc("t6.idle", 0, 0, 1, 0, 0);
        clr_req();
        cyc("t6.c0", 1, 1, 1, 1, 0);
        check_eq("t6.c1.clk", 32'(div_clk_out), 1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("t6.async.clk",  32'(div_clk_out), 0);
        check_eq("t6.async.tick", 32'(div_tick),    0);
        check_eq("t6.async.busy", 32'(busy),        0);
        check_eq("t6.async.div",  32'(dut.cur_div_q), 4);
        #3;
        rst = 1'b0;
        step();
        for (int i = 0; i < 3; i++) cyc("t6.idle2", 0, 0, 1, 0, 0);
        check_eq("t6.cur_div", 32'(dut.cur_div_q), 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
